// File: rtl/vga_pkg.sv
// Shared types and constants for the MPU write path into the VRAM memory manager.
package vga_pkg;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } write_entry_t;

    localparam logic [2:0] REG_ADDR_L = 3'd0;
    localparam logic [2:0] REG_ADDR_M = 3'd1;
    localparam logic [2:0] REG_ADDR_H = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_INCR   = 3'd4;
    localparam logic [2:0] REG_FILL   = 3'd5;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead FIFO of write entries; the head is visible without a read strobe
// and the last popped entry stays on the bus while the queue is empty.
module sync_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  write_entry_t           push_data,
    input  logic                   pop,
    output write_entry_t           head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    write_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    write_entry_t     last_q, last_d;
    logic             push_ok, pop_ok;

    always_comb begin
        full     = (count_q == (PTR_W+1)'(DEPTH));
        empty    = (count_q == '0);
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop_ok);
        last_d   = pop_ok ? mem[rd_ptr_q] : last_q;
        head     = empty ? last_q : mem[rd_ptr_q];
        count    = count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: pointers and count define which slots are valid.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mpu_write_queue.sv
// MPU register decode, auto-incrementing VRAM address and fill engine feeding
// a show-ahead queue of pending {addr, data} writes for the memory manager.
module mpu_write_queue
    import vga_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             chipSelect,
    input  logic                             writeEnable,
    input  logic [2:0]                       registerSelect,
    input  logic [DATA_WIDTH-1:0]            registerData,
    input  logic                             pendingWriteQueueReadRequest,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] pendingWriteQueueReadBus,
    output logic                             pendingWriteQueueReadEmpty,
    output logic                             fillBusy,
    output logic                             overflow
);

    logic sync1_q, sync2_q, sync3_q, pulse_q, pulse_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_next;
    logic [DATA_WIDTH-1:0] incr_q, incr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [8:0]            count_q, count_d;
    fill_state_t           state_q, state_d;
    logic                  overflow_q, overflow_d;

    logic                       push;
    write_entry_t               push_entry;
    write_entry_t               fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    always_comb begin
        pulse_d    = sync2_q & ~sync3_q;
        addr_next  = addr_q + ADDR_WIDTH'(incr_q);
        addr_d     = addr_q;
        incr_d     = incr_q;
        data_d     = data_q;
        count_d    = count_q;
        state_d    = state_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        push_entry = '{addr: addr_q, data: data_q};

        unique case (state_q)
            IDLE: begin
                if (pulse_q) begin
                    case (registerSelect)
                        REG_ADDR_L: addr_d[7:0]  = registerData;
                        REG_ADDR_M: addr_d[15:8] = registerData;
                        REG_ADDR_H: addr_d[16]   = registerData[0];
                        REG_DATA: begin
                            data_d     = registerData;
                            push_entry = '{addr: addr_q, data: registerData};
                            if (!fifo_full) begin
                                push   = 1'b1;
                                addr_d = addr_next;
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                        REG_INCR: incr_d = registerData;
                        REG_FILL: begin
                            count_d = (registerData == '0) ? 9'd256 : {1'b0, registerData};
                            state_d = FILL;
                        end
                        default: ;
                    endcase
                end
            end
            // MPU strobes are dropped here; the fill only waits on queue space.
            FILL: begin
                if (!fifo_full) begin
                    push    = 1'b1;
                    addr_d  = addr_next;
                    count_d = count_q - 9'd1;
                    if (count_q == 9'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            pulse_q    <= 1'b0;
            addr_q     <= '0;
            incr_q     <= DATA_WIDTH'(1);
            data_q     <= '0;
            count_q    <= '0;
            state_q    <= IDLE;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= chipSelect & writeEnable;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            pulse_q    <= pulse_d;
            addr_q     <= addr_d;
            incr_q     <= incr_d;
            data_q     <= data_d;
            count_q    <= count_d;
            state_q    <= state_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pendingWriteQueueReadRequest),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign pendingWriteQueueReadBus   = fifo_head;
    assign pendingWriteQueueReadEmpty = fifo_empty;
    assign fillBusy                   = (state_q == FILL);
    assign overflow                   = overflow_q;

endmodule

// File: tb/tb_mpu_write_queue.sv
// Bench for mpu_write_queue: directed scenarios plus random MPU traffic checked
// against a transaction-level model of the register map and the write stream.
module tb_mpu_write_queue;
    import vga_pkg::*;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        chipSelect;
    logic        writeEnable;
    logic [2:0]  registerSelect;
    logic [7:0]  registerData;
    logic        pendingWriteQueueReadRequest;
    logic [24:0] pendingWriteQueueReadBus;
    logic        pendingWriteQueueReadEmpty;
    logic        fillBusy;
    logic        overflow;

    int testsRun    = 0;
    int testsFailed = 0;
    int busyCycles  = 0;

    // Reference model state: current address, increment, data register, sticky
    // overflow and the ordered stream of entries the reader should still see.
    int          mAddr;
    int          mIncr;
    int          mData;
    bit          mOverflow;
    logic [24:0] expQ[$];
    logic [24:0] lastPopped;

    mpu_write_queue dut (
        .clock                       (clock),
        .reset                       (reset),
        .chipSelect                  (chipSelect),
        .writeEnable                 (writeEnable),
        .registerSelect              (registerSelect),
        .registerData                (registerData),
        .pendingWriteQueueReadRequest(pendingWriteQueueReadRequest),
        .pendingWriteQueueReadBus    (pendingWriteQueueReadBus),
        .pendingWriteQueueReadEmpty  (pendingWriteQueueReadEmpty),
        .fillBusy                    (fillBusy),
        .overflow                    (overflow)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (fillBusy === 1'b1) busyCycles++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic void modelReset();
        mAddr     = 0;
        mIncr     = 1;
        mData     = 0;
        mOverflow = 1'b0;
        expQ.delete();
    endfunction

    function automatic void modelAdvance();
        mAddr = (mAddr + mIncr) % 131072;
    endfunction

    // Fill entries are queued all at once: the engine stalls but never drops.
    function automatic void modelWrite(input logic [2:0] sel, input logic [7:0] d);
        int n;
        case (sel)
            3'd0: mAddr = (mAddr & 'h1FF00) | int'(d);
            3'd1: mAddr = (mAddr & 'h100FF) | (int'(d) << 8);
            3'd2: mAddr = (mAddr & 'h0FFFF) | (int'(d[0]) << 16);
            3'd3: begin
                mData = int'(d);
                if (expQ.size() < DEPTH) begin
                    expQ.push_back({17'(mAddr), d});
                    modelAdvance();
                end else begin
                    mOverflow = 1'b1;
                end
            end
            3'd4: mIncr = int'(d);
            3'd5: begin
                n = (d == 8'd0) ? 256 : int'(d);
                for (int i = 0; i < n; i++) begin
                    expQ.push_back({17'(mAddr), 8'(mData)});
                    modelAdvance();
                end
            end
            default: ;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] d);
        @(negedge clock);
        registerSelect = sel;
        registerData   = d;
        chipSelect     = 1'b1;
        writeEnable    = 1'b1;
        repeat (6) @(negedge clock);
        chipSelect  = 1'b0;
        writeEnable = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic mpuWrite(input logic [2:0] sel, input logic [7:0] d);
        applyStimulus(sel, d);
        modelWrite(sel, d);
    endtask

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        modelReset();
    endtask

    task automatic drainEntries(input int n);
        int budget = 3000;
        int done   = 0;
        while (done < n && budget > 0) begin
            @(negedge clock);
            pendingWriteQueueReadRequest = 1'b0;
            if (!pendingWriteQueueReadEmpty) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_entry", 32'(pendingWriteQueueReadBus), 32'h0);
                    break;
                end
                checkOutput("head", 32'(pendingWriteQueueReadBus), 32'(expQ[0]));
                lastPopped = expQ.pop_front();
                pendingWriteQueueReadRequest = 1'b1;
                done++;
            end else begin
                budget--;
            end
        end
        if (done < n) checkOutput("drain_timeout", 32'(done), 32'(n));
        @(negedge clock);
        pendingWriteQueueReadRequest = 1'b0;
    endtask

    task automatic waitFillDone(input bit popping);
        int budget = 3000;
        while (budget > 0) begin
            @(negedge clock);
            pendingWriteQueueReadRequest = 1'b0;
            if (!fillBusy) break;
            if (popping && !pendingWriteQueueReadEmpty && expQ.size() > 0) begin
                checkOutput("fill_head", 32'(pendingWriteQueueReadBus), 32'(expQ[0]));
                lastPopped = expQ.pop_front();
                pendingWriteQueueReadRequest = 1'b1;
            end
            budget--;
        end
        if (budget == 0) checkOutput("fill_timeout", 32'(fillBusy), 32'h0);
    endtask

    initial begin
        int          latency;
        logic [2:0]  sel;
        logic [7:0]  d;
        int          k;

        reset          = 1'b1;
        chipSelect     = 1'b0;
        writeEnable    = 1'b0;
        registerSelect = '0;
        registerData   = '0;
        pendingWriteQueueReadRequest = 1'b0;
        modelReset();
        repeat (3) @(negedge clock);
        reset = 1'b0;

        checkOutput("reset_empty", 32'(pendingWriteQueueReadEmpty), 32'h1);
        checkOutput("reset_bus", 32'(pendingWriteQueueReadBus), 32'h0);
        checkOutput("reset_busy", 32'(fillBusy), 32'h0);
        checkOutput("reset_overflow", 32'(overflow), 32'h0);

        // Address setup, strobe-to-empty latency and auto increment
        mpuWrite(REG_ADDR_L, 8'h34);
        mpuWrite(REG_ADDR_M, 8'h12);
        mpuWrite(REG_ADDR_H, 8'h01);
        @(negedge clock);
        registerSelect = REG_DATA;
        registerData   = 8'hAB;
        chipSelect     = 1'b1;
        writeEnable    = 1'b1;
        modelWrite(REG_DATA, 8'hAB);
        latency = 0;
        while (pendingWriteQueueReadEmpty && latency < 12) begin
            @(negedge clock);
            latency++;
        end
        checkOutput("latency", 32'(latency), 32'd4);
        checkOutput("first_head", 32'(pendingWriteQueueReadBus), 32'h11234AB);
        repeat (4) @(negedge clock);
        chipSelect  = 1'b0;
        writeEnable = 1'b0;
        repeat (3) @(negedge clock);
        mpuWrite(REG_DATA, 8'hCD);
        drainEntries(2);
        checkOutput("last_popped_addr", 32'(lastPopped), 32'h11235CD);

        // Increment of 2 across the 17-bit wrap
        mpuWrite(REG_INCR, 8'd2);
        mpuWrite(REG_ADDR_L, 8'hFF);
        mpuWrite(REG_ADDR_M, 8'hFF);
        mpuWrite(REG_ADDR_H, 8'hFF);
        mpuWrite(REG_DATA, 8'h55);
        mpuWrite(REG_DATA, 8'h55);
        checkOutput("wrap_head", 32'(pendingWriteQueueReadBus), 32'h1FFFF55);
        drainEntries(2);
        checkOutput("wrap_second", 32'(lastPopped), 32'h0000155);
        checkOutput("empty_after_drain", 32'(pendingWriteQueueReadEmpty), 32'h1);
        checkOutput("bus_holds_last", 32'(pendingWriteQueueReadBus), 32'h0000155);

        // Short fill: busy exactly three cycles
        mpuWrite(REG_INCR, 8'd1);
        mpuWrite(REG_ADDR_L, 8'h00);
        mpuWrite(REG_ADDR_M, 8'h01);
        mpuWrite(REG_ADDR_H, 8'h00);
        mpuWrite(REG_DATA, 8'h07);
        drainEntries(1);
        busyCycles = 0;
        mpuWrite(REG_FILL, 8'd3);
        waitFillDone(1'b0);
        checkOutput("fill3_busy_cycles", 32'(busyCycles), 32'd3);
        checkOutput("fill3_overflow", 32'(overflow), 32'h0);
        drainEntries(3);
        checkOutput("fill3_last", 32'(lastPopped), 32'h0010307);

        // Fill of 256 with the reader stalled, then released
        mpuWrite(REG_INCR, 8'd3);
        mpuWrite(REG_ADDR_L, 8'h00);
        mpuWrite(REG_ADDR_M, 8'hFF);
        mpuWrite(REG_ADDR_H, 8'h01);
        mpuWrite(REG_DATA, 8'h5A);
        drainEntries(1);
        mpuWrite(REG_FILL, 8'd0);
        repeat (40) @(negedge clock);
        checkOutput("fill256_stalled_busy", 32'(fillBusy), 32'h1);
        checkOutput("fill256_not_empty", 32'(pendingWriteQueueReadEmpty), 32'h0);
        drainEntries(expQ.size());
        checkOutput("fill256_done", 32'(fillBusy), 32'h0);
        checkOutput("fill256_overflow", 32'(overflow), 32'h0);
        checkOutput("fill256_empty", 32'(pendingWriteQueueReadEmpty), 32'h1);

        // Writes ignored while busy, then DATA overflow on a full queue
        resetDut();
        for (int i = 0; i < DEPTH; i++) mpuWrite(REG_DATA, 8'($urandom));
        mpuWrite(REG_FILL, 8'd2);
        repeat (5) @(negedge clock);
        checkOutput("full_fill_busy", 32'(fillBusy), 32'h1);
        applyStimulus(REG_DATA, 8'h99);
        checkOutput("busy_write_no_overflow", 32'(overflow), 32'h0);
        checkOutput("busy_write_still_busy", 32'(fillBusy), 32'h1);
        drainEntries(expQ.size());
        waitFillDone(1'b0);
        for (int i = 0; i < DEPTH; i++) mpuWrite(REG_DATA, 8'($urandom));
        mpuWrite(REG_DATA, 8'hEE);
        checkOutput("overflow_set", 32'(overflow), 32'(mOverflow));
        drainEntries(DEPTH);
        mpuWrite(REG_DATA, 8'h42);
        drainEntries(1);
        checkOutput("overflow_sticky", 32'(overflow), 32'h1);

        // Reset during an active fill
        mpuWrite(REG_FILL, 8'd0);
        repeat (30) @(negedge clock);
        checkOutput("prereset_busy", 32'(fillBusy), 32'h1);
        resetDut();
        checkOutput("midfill_reset_empty", 32'(pendingWriteQueueReadEmpty), 32'h1);
        checkOutput("midfill_reset_busy", 32'(fillBusy), 32'h0);
        checkOutput("midfill_reset_overflow", 32'(overflow), 32'h0);
        checkOutput("midfill_reset_bus", 32'(pendingWriteQueueReadBus), 32'h0);
        @(negedge clock);
        pendingWriteQueueReadRequest = 1'b1;
        @(negedge clock);
        pendingWriteQueueReadRequest = 1'b0;
        checkOutput("pop_empty_empty", 32'(pendingWriteQueueReadEmpty), 32'h1);
        checkOutput("pop_empty_bus", 32'(pendingWriteQueueReadBus), 32'h0);
        mpuWrite(REG_DATA, 8'h11);
        mpuWrite(REG_DATA, 8'h11);
        drainEntries(2);
        checkOutput("reset_incr_one", 32'(lastPopped), 32'h0000111);

        // Random register traffic with sporadic reads
        for (int it = 0; it < 60; it++) begin
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) sel = REG_DATA;
            d = 8'($urandom);
            if (sel == REG_FILL) d = 8'($urandom_range(1, 6));
            mpuWrite(sel, d);
            if (sel == REG_FILL) waitFillDone(1'b1);
            checkOutput("rand_overflow", 32'(overflow), 32'(mOverflow));
            k = $urandom_range(0, 2);
            if (k > expQ.size()) k = expQ.size();
            if (k > 0) drainEntries(k);
        end
        drainEntries(expQ.size());
        checkOutput("rand_final_empty", 32'(pendingWriteQueueReadEmpty), 32'h1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
